// File: rtl/operand_sel_pipe_if.sv
// ---------------------------------------------------------------------------
// operand_sel_pipe_if
// Purpose : bundles the producer and consumer handshake signals of
//           operand_sel_pipe into one interface.
// Ports   : in_bus/sel/in_valid/in_ready  - producer side (capture channel)
//           out_data/out_sel/out_valid/out_ready - consumer side (queue head)
//           err/clr_err - sticky out-of-range flag and its clear, present
//           only when OPSEL_ERR_EN is defined
// Modports: master - the agent that drives in_* and out_ready (producer and
//                    consumer environment)
//           slave  - the operand_sel_pipe block itself
// Config  : `OPSEL_ERR_EN adds err/clr_err.
// ---------------------------------------------------------------------------
interface operand_sel_pipe_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
`ifdef OPSEL_ERR_EN
  logic                    err;
  logic                    clr_err;
`endif

`ifdef OPSEL_ERR_EN
  modport master (
    output in_bus, sel, in_valid, out_ready, clr_err,
    input  in_ready, out_data, out_sel, out_valid, err
  );
  modport slave (
    input  in_bus, sel, in_valid, out_ready, clr_err,
    output in_ready, out_data, out_sel, out_valid, err
  );
`else
  modport master (
    output in_bus, sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
  modport slave (
    input  in_bus, sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
`endif
endinterface

// File: rtl/operand_sel_pipe.sv
// ---------------------------------------------------------------------------
// operand_sel_pipe
// Purpose : selects one of NUM_IN operand channels at capture time and queues
//           the selected operand (with its raw select value) in a two-entry
//           elastic buffer: a head register feeding the output plus a skid
//           register that absorbs one extra entry while the consumer stalls.
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - operand_sel_pipe_if.slave
//                  in_bus/sel/in_valid/in_ready   producer handshake
//                  out_data/out_sel/out_valid/out_ready consumer handshake
//                  err/clr_err  (OPSEL_ERR_EN only) sticky out-of-range flag
// Config  : `OPSEL_ERR_EN - enables the sticky err flag that records any
//           accepted select value >= NUM_IN. Without it the out-of-range
//           behaviour (data 0, raw sel passed through) is unchanged.
// Params  : WIDTH (channel width), NUM_IN (2..16 channels), SEL_W with
//           2**SEL_W >= NUM_IN; the interface instance must use the same
//           parameter values.
// ---------------------------------------------------------------------------
module operand_sel_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_sel_pipe_if.slave    bus
);

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Channel multiplexer; any select outside 0..NUM_IN-1 yields zero data.
  function automatic logic [WIDTH-1:0] pick_channel(
    input logic [NUM_IN*WIDTH-1:0] bus_v,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      r = (int'(s) == k) ? bus_v[k*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  // True when the select value addresses a channel that does not exist.
  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] s);
    return (int'(s) >= NUM_IN);
  endfunction

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [SEL_W-1:0] head_sel_q,  head_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s;
  logic             pop_s;
  logic [WIDTH-1:0] cap_data_s;

  // Handshakes use only registered ready/valid, so neither depends on the
  // other side's input in the same cycle.
  assign accept_s   = bus.in_valid & in_ready_q;
  assign pop_s      = out_valid_q & bus.out_ready;
  assign cap_data_s = pick_channel(bus.in_bus, bus.sel);

  // Next-state, buffer-load and registered-flag computation.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d     = ST_ONE;
          head_data_d = cap_data_s;
          head_sel_d  = bus.sel;
        end else begin
          state_d     = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !pop_s) begin
          // Consumer is stalling: park the new entry behind the head.
          state_d     = ST_FULL;
          skid_data_d = cap_data_s;
          skid_sel_d  = bus.sel;
        end else if (pop_s && !accept_s) begin
          state_d     = ST_EMPTY;
        end else if (accept_s && pop_s) begin
          // Streaming case: head is replaced in place, skid stays unused.
          state_d     = ST_ONE;
          head_data_d = cap_data_s;
          head_sel_d  = bus.sel;
        end else begin
          state_d     = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can change occupancy.
        if (pop_s) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
        end else begin
          state_d     = ST_FULL;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
      end
    endcase

    // Flags follow the next state so they are plain flops at the ports.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, buffer and handshake flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= {WIDTH{1'b0}};
      head_sel_q  <= {SEL_W{1'b0}};
      skid_data_q <= {WIDTH{1'b0}};
      skid_sel_q  <= {SEL_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_data_q;
  assign bus.out_sel   = head_sel_q;

`ifdef OPSEL_ERR_EN
  logic err_q, err_d;

  // Sticky error: a new out-of-range accept wins over a same-cycle clear.
  always_comb begin
    if (accept_s && sel_out_of_range(bus.sel)) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
module tb_operand_sel_pipe;

  logic clk;
  logic rst;

  operand_sel_pipe_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) bus4 ();
  operand_sel_pipe_if #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) bus3 ();

  operand_sel_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  operand_sel_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock, then settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] in_bus;
    logic [1:0]  sel;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
  } ent_t;

  localparam logic [63:0] BASE = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  vec_t vecs[6];
  ent_t q[$];

  initial begin
    logic [63:0] rnd_bus;
    logic [1:0]  rnd_sel;
    logic        exp_rdy, acc, pop;
    ent_t        e;
    int          sh;

    vecs[0] = '{BASE, 2'd0, 16'h1111};
    vecs[1] = '{BASE, 2'd1, 16'h2222};
    vecs[2] = '{BASE, 2'd2, 16'h3333};
    vecs[3] = '{BASE, 2'd3, 16'h4444};
    vecs[4] = '{64'hDEAD_BEEF_0123_4567, 2'd1, 16'h0123};
    vecs[5] = '{64'hA5A5_5A5A_FFFF_0000, 2'd3, 16'hA5A5};

    bus4.in_bus    = BASE;
    bus4.sel       = 2'd0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus3.in_bus    = {16'h3333, 16'h2222, 16'h1111};
    bus3.sel       = 2'd0;
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b0;
`ifdef OPSEL_ERR_EN
    bus4.clr_err   = 1'b0;
    bus3.clr_err   = 1'b0;
`endif

    // ---- reset state ----
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready",  bus4.in_ready,  1);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_out_data",  bus4.out_data,  0);
    check("rst_out_sel",   bus4.out_sel,   0);
`ifdef OPSEL_ERR_EN
    check("rst_err", bus3.err, 0);
`endif
    step();
    step();
    #2 rst = 1'b0;
    step();

    // ---- single transfer latency, sel=2 ----
    bus4.in_bus = BASE; bus4.sel = 2'd2; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    check("lat_out_valid", bus4.out_valid, 1);
    check("lat_out_data",  bus4.out_data,  16'h3333);
    check("lat_out_sel",   bus4.out_sel,   2);
    step();
    check("lat_drained", bus4.out_valid, 0);

    // ---- table-driven single captures ----
    foreach (vecs[i]) begin
      bus4.in_bus = vecs[i].in_bus; bus4.sel = vecs[i].sel;
      bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
      step();
      bus4.in_valid = 1'b0;
      bus4.in_bus = ~vecs[i].in_bus;   // capture must not track later bus
      #1;
      check($sformatf("vec%0d_valid", i), bus4.out_valid, 1);
      check($sformatf("vec%0d_data", i),  bus4.out_data,  vecs[i].exp_data);
      check($sformatf("vec%0d_sel", i),   bus4.out_sel,   vecs[i].sel);
      step();
      check($sformatf("vec%0d_empty", i), bus4.out_valid, 0);
    end

    // ---- fill to FULL under stall, then drain ----
    bus4.in_bus = BASE; bus4.out_ready = 1'b0;
    bus4.sel = 2'd0; bus4.in_valid = 1'b1;
    step();
    bus4.sel = 2'd1;
    step();
    bus4.in_valid = 1'b0;
    check("full_in_ready", bus4.in_ready, 0);
    check("full_valid",    bus4.out_valid, 1);
    check("full_head",     bus4.out_data, 16'h1111);
    step();
    check("full_hold_data", bus4.out_data, 16'h1111);
    check("full_hold_sel",  bus4.out_sel,  0);
    bus4.out_ready = 1'b1;
    #1 check("drain0", bus4.out_data, 16'h1111);
    step();
    check("drain1", bus4.out_data, 16'h2222);
    check("drain1_valid", bus4.out_valid, 1);
    check("drain1_ready", bus4.in_ready, 1);
    step();
    check("drain_empty", bus4.out_valid, 0);

    // ---- back-to-back stream 0,1,2,3 ----
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.sel = 2'(i);
      step();
      check($sformatf("stream%0d_data", i),  bus4.out_data, BASE[i*16 +: 16]);
      check($sformatf("stream%0d_valid", i), bus4.out_valid, 1);
      check($sformatf("stream%0d_ready", i), bus4.in_ready, 1);
    end
    bus4.in_valid = 1'b0;
    step();
    check("stream_empty", bus4.out_valid, 0);

    // ---- reset while FULL ----
    bus4.out_ready = 1'b0; bus4.in_valid = 1'b1;
    bus4.sel = 2'd1;
    step();
    bus4.sel = 2'd2;
    step();
    bus4.in_valid = 1'b0;
    check("prerst_full", bus4.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", bus4.out_valid, 0);
    check("midrst_ready", bus4.in_ready, 1);
    check("midrst_data",  bus4.out_data, 0);
    #1 rst = 1'b0;
    bus4.out_ready = 1'b1;
    step();
    step();
    check("postrst_no_stale", bus4.out_valid, 0);
    bus4.sel = 2'd3; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    check("postrst_valid", bus4.out_valid, 1);
    check("postrst_data",  bus4.out_data, 16'h4444);
    step();
    check("postrst_empty", bus4.out_valid, 0);

    // ---- out-of-range select on the 3-channel block ----
    bus3.sel = 2'd3; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    check("oob_valid", bus3.out_valid, 1);
    check("oob_data",  bus3.out_data,  0);
    check("oob_sel",   bus3.out_sel,   3);
`ifdef OPSEL_ERR_EN
    check("oob_err_set", bus3.err, 1);
    step();
    step();
    check("oob_err_sticky", bus3.err, 1);
    bus3.clr_err = 1'b1;
    step();
    bus3.clr_err = 1'b0;
    check("oob_err_clr", bus3.err, 0);
    // set and clear together: set wins
    bus3.sel = 2'd3; bus3.in_valid = 1'b1; bus3.clr_err = 1'b1;
    step();
    bus3.in_valid = 1'b0; bus3.clr_err = 1'b0;
    check("oob_err_setwins", bus3.err, 1);
    // in-range accept does not set err
    bus3.clr_err = 1'b1;
    step();
    bus3.clr_err = 1'b0;
    bus3.sel = 2'd2; bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    check("inrange_no_err", bus3.err, 0);
`else
    step();
`endif
    bus3.sel = 2'd2; bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    check("ch2_data_3in", bus3.out_data, 16'h3333);
    step();

    // ---- randomized traffic against a queue scoreboard ----
    rst = 1'b1;
    #1 rst = 1'b0;
    q.delete();
    step();
    for (int c = 0; c < 10000; c++) begin
      rnd_bus = {$urandom, $urandom};
      rnd_sel = 2'($urandom_range(0, 3));
      bus4.in_bus    = rnd_bus;
      bus4.sel       = rnd_sel;
      bus4.in_valid  = ($urandom_range(0, 3) != 0);
      bus4.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() < 2);
      check("rnd_in_ready",  bus4.in_ready,  exp_rdy);
      check("rnd_out_valid", bus4.out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        check("rnd_out_data", bus4.out_data, q[0].d);
        check("rnd_out_sel",  bus4.out_sel,  q[0].s);
      end
      acc = bus4.in_valid && exp_rdy;
      pop = (q.size() > 0) && bus4.out_ready;
      sh  = int'(rnd_sel) * 16;
      e.d = 16'(rnd_bus >> sh);
      e.s = rnd_sel;
      step();
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
